vram_arbiter: RTL and testbench

Two-port arbiter for the single-port video RAM in QuickSilverNEO. It shares the RAM between the VGA scanout fetch (high priority, pixel deadline) and the draw engine (reads and writes, best effort). Each cycle it issues one registered RAM access and routes the synchronous-read data back to the port that issued it. An optional fairness guard bounds how long the draw engine can wait.

---
 rtl/vram_arbiter_if.sv | 38 +++
 rtl/vram_arbiter.sv | 147 ++++++++++++++
 tb/tb_vram_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the RAM macro.
// master = requesters/RAM side, slave = arbiter side.
interface vram_arbiter_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_gnt;
  logic              scan_rvalid;
  logic [DATA_W-1:0] scan_rdata;

  logic              draw_req;
  logic              draw_we;
  logic [ADDR_W-1:0] draw_addr;
  logic [DATA_W-1:0] draw_wdata;
  logic              draw_gnt;
  logic              draw_rvalid;
  logic [DATA_W-1:0] draw_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output scan_req, scan_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    input  scan_gnt, scan_rvalid, scan_rdata, draw_gnt, draw_rvalid, draw_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  scan_req, scan_addr, draw_req, draw_we, draw_addr, draw_wdata, mem_rdata,
    output scan_gnt, scan_rvalid, scan_rdata, draw_gnt, draw_rvalid, draw_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Scanout/draw arbiter for the single-port video RAM: one registered access per cycle.
// Define VRAM_ARB_FAIRNESS_EN to compile in the draw starvation guard.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  vram_arbiter_if.slave bus
);

  logic scan_gnt_c;
  logic draw_gnt_c;
  logic scan_xfer_c;
  logic draw_xfer_c;
  logic force_c;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Read tag pipeline: owner 1 = draw, 0 = scan.
  logic tag1_valid_q, tag1_valid_d;
  logic tag1_owner_q, tag1_owner_d;
  logic tag2_valid_q, tag2_valid_d;
  logic tag2_owner_q, tag2_owner_d;

  logic              scan_rvalid_c;
  logic              draw_rvalid_c;
  logic [DATA_W-1:0] scan_rdata_q, scan_rdata_d;
  logic [DATA_W-1:0] draw_rdata_q, draw_rdata_d;

`ifdef VRAM_ARB_FAIRNESS_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign force_c = (wait_cnt_q == LIMIT) && bus.draw_req;

  // Count consecutive denied draw cycles, saturating at the limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.draw_req || draw_gnt_c) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_limit;

  assign force_c      = 1'b0;
  assign unused_limit = ^8'(STARVE_LIMIT);
`endif

  assign scan_gnt_c  = bus.scan_req && !force_c;
  assign draw_gnt_c  = force_c || (bus.draw_req && !bus.scan_req);
  assign scan_xfer_c = bus.scan_req && scan_gnt_c;
  assign draw_xfer_c = bus.draw_req && draw_gnt_c;

  // Issue stage and read tagging.
  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tag1_valid_d = 1'b0;
    tag1_owner_d = 1'b0;
    if (scan_xfer_c) begin
      mem_en_d     = 1'b1;
      mem_addr_d   = bus.scan_addr;
      tag1_valid_d = 1'b1;
    end else if (draw_xfer_c) begin
      mem_en_d     = 1'b1;
      mem_we_d     = bus.draw_we;
      mem_addr_d   = bus.draw_addr;
      mem_wdata_d  = bus.draw_wdata;
      tag1_valid_d = !bus.draw_we;
      tag1_owner_d = 1'b1;
    end
    tag2_valid_d = tag1_valid_q;
    tag2_owner_d = tag1_owner_q;
  end

  // Return path: read data passes straight through in the tagged cycle, then holds.
  assign scan_rvalid_c = tag2_valid_q && !tag2_owner_q;
  assign draw_rvalid_c = tag2_valid_q &&  tag2_owner_q;

  always_comb begin
    scan_rdata_d = scan_rdata_q;
    draw_rdata_d = draw_rdata_q;
    if (scan_rvalid_c) begin
      scan_rdata_d = bus.mem_rdata;
    end
    if (draw_rvalid_c) begin
      draw_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag1_valid_q <= 1'b0;
      tag1_owner_q <= 1'b0;
      tag2_valid_q <= 1'b0;
      tag2_owner_q <= 1'b0;
      scan_rdata_q <= '0;
      draw_rdata_q <= '0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag1_valid_q <= tag1_valid_d;
      tag1_owner_q <= tag1_owner_d;
      tag2_valid_q <= tag2_valid_d;
      tag2_owner_q <= tag2_owner_d;
      scan_rdata_q <= scan_rdata_d;
      draw_rdata_q <= draw_rdata_d;
    end
  end

  assign bus.scan_gnt    = scan_gnt_c;
  assign bus.draw_gnt    = draw_gnt_c;
  assign bus.scan_rvalid = scan_rvalid_c;
  assign bus.draw_rvalid = draw_rvalid_c;
  assign bus.scan_rdata  = scan_rdata_d;
  assign bus.draw_rdata  = draw_rdata_d;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM model.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ram_init(int i);
    case (i)
      16:      return 8'hE3;
      32:      return 8'h3C;
      48:      return 8'hA5;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Synchronous single-port RAM; the low 640 words are (re)loaded while in reset.
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 640; i++) ram[i] <= ram_init(i);
      bus.mem_rdata <= 8'h00;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  typedef struct {
    logic        sreq;
    logic [14:0] saddr;
    logic        dreq;
    logic        dwe;
    logic [14:0] daddr;
    logic [7:0]  dwd;
    logic        e_sg;
    logic        e_dg;
    logic        e_en;
    logic        e_we;
    logic [14:0] e_addr;
    logic [7:0]  e_wd;
    logic        e_sv;
    logic        e_dv;
    logic [7:0]  e_srd;
    logic [7:0]  e_drd;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sreq, input logic [14:0] saddr, input logic dreq,
                       input logic dwe, input logic [14:0] daddr, input logic [7:0] dwd);
    bus.scan_req   = sreq;
    bus.scan_addr  = saddr;
    bus.draw_req   = dreq;
    bus.draw_we    = dwe;
    bus.draw_addr  = daddr;
    bus.draw_wdata = dwd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs_zero(input string tag);
    chk({tag, "_mem_en"},      32'(bus.mem_en),      32'd0);
    chk({tag, "_mem_we"},      32'(bus.mem_we),      32'd0);
    chk({tag, "_mem_addr"},    32'(bus.mem_addr),    32'd0);
    chk({tag, "_mem_wdata"},   32'(bus.mem_wdata),   32'd0);
    chk({tag, "_scan_rvalid"}, 32'(bus.scan_rvalid), 32'd0);
    chk({tag, "_draw_rvalid"}, 32'(bus.draw_rvalid), 32'd0);
    chk({tag, "_scan_rdata"},  32'(bus.scan_rdata),  32'd0);
    chk({tag, "_draw_rdata"},  32'(bus.draw_rdata),  32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(L, 15'h0, L, L, 15'h0, 8'h00);

    // Reset state, then a scan read that reset must drop.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_regs_zero("reset");
    chk("reset_scan_gnt", 32'(bus.scan_gnt), 32'd0);
    chk("reset_draw_gnt", 32'(bus.draw_gnt), 32'd0);
    next_cycle();
    drive(H, 15'h0010, L, L, 15'h0, 8'h00);
    @(negedge clk);
    chk("inflight_scan_gnt", 32'(bus.scan_gnt), 32'd1);
    next_cycle();
    drive(L, 15'h0, L, L, 15'h0, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("inflight_mem_en", 32'(bus.mem_en), 32'd1);
    next_cycle();
    @(negedge clk);
    chk_regs_zero("midreset");
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dropped_scan_rvalid", 32'(bus.scan_rvalid), 32'd0);
      next_cycle();
    end

    // Single read, collision, draw write then read-after-write.
    vecs[0]  = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,L,L,15'h0000,8'h00,L,L,8'h00,8'h00};
    vecs[1]  = '{H,15'h0010,L,L,15'h0000,8'h00, H,L,L,L,15'h0000,8'h00,L,L,8'h00,8'h00};
    vecs[2]  = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,H,L,15'h0010,8'h00,L,L,8'h00,8'h00};
    vecs[3]  = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,L,L,15'h0010,8'h00,H,L,8'hE3,8'h00};
    vecs[4]  = '{H,15'h0020,H,L,15'h0030,8'h00, H,L,L,L,15'h0010,8'h00,L,L,8'hE3,8'h00};
    vecs[5]  = '{L,15'h0000,H,L,15'h0030,8'h00, L,H,H,L,15'h0020,8'h00,L,L,8'hE3,8'h00};
    vecs[6]  = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,H,L,15'h0030,8'h00,H,L,8'h3C,8'h00};
    vecs[7]  = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,L,L,15'h0030,8'h00,L,H,8'h3C,8'hA5};
    vecs[8]  = '{L,15'h0000,H,H,15'h1234,8'h5A, L,H,L,L,15'h0030,8'h00,L,L,8'h3C,8'hA5};
    vecs[9]  = '{L,15'h0000,H,L,15'h1234,8'h5A, L,H,H,H,15'h1234,8'h5A,L,L,8'h3C,8'hA5};
    vecs[10] = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,H,L,15'h1234,8'h5A,L,L,8'h3C,8'hA5};
    vecs[11] = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,L,L,15'h1234,8'h5A,L,H,8'h3C,8'h5A};
    vecs[12] = '{L,15'h0000,L,L,15'h0000,8'h00, L,L,L,L,15'h1234,8'h5A,L,L,8'h3C,8'h5A};

    for (int v = 0; v < 13; v++) begin
      drive(vecs[v].sreq, vecs[v].saddr, vecs[v].dreq, vecs[v].dwe, vecs[v].daddr, vecs[v].dwd);
      @(negedge clk);
      chk($sformatf("v%0d_scan_gnt", v),    32'(bus.scan_gnt),    32'(vecs[v].e_sg));
      chk($sformatf("v%0d_draw_gnt", v),    32'(bus.draw_gnt),    32'(vecs[v].e_dg));
      chk($sformatf("v%0d_mem_en", v),      32'(bus.mem_en),      32'(vecs[v].e_en));
      chk($sformatf("v%0d_mem_we", v),      32'(bus.mem_we),      32'(vecs[v].e_we));
      chk($sformatf("v%0d_mem_addr", v),    32'(bus.mem_addr),    32'(vecs[v].e_addr));
      chk($sformatf("v%0d_mem_wdata", v),   32'(bus.mem_wdata),   32'(vecs[v].e_wd));
      chk($sformatf("v%0d_scan_rvalid", v), 32'(bus.scan_rvalid), 32'(vecs[v].e_sv));
      chk($sformatf("v%0d_draw_rvalid", v), 32'(bus.draw_rvalid), 32'(vecs[v].e_dv));
      chk($sformatf("v%0d_scan_rdata", v),  32'(bus.scan_rdata),  32'(vecs[v].e_srd));
      chk($sformatf("v%0d_draw_rdata", v),  32'(bus.draw_rdata),  32'(vecs[v].e_drd));
      next_cycle();
    end

    // Starvation: scan held high with a draw write pending throughout.
    drive(H, 15'h0100, H, H, 15'h2000, 8'h77);
`ifdef VRAM_ARB_FAIRNESS_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_draw_gnt", i), 32'(bus.draw_gnt), 32'((i == 3) || (i == 7)));
      chk($sformatf("starve%0d_scan_gnt", i), 32'(bus.scan_gnt), 32'(!((i == 3) || (i == 7))));
      if (i == 4) begin
        chk("starve_forced_mem_we",   32'(bus.mem_we),   32'd1);
        chk("starve_forced_mem_addr", 32'(bus.mem_addr), 32'h2000);
      end
      next_cycle();
    end
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_draw_gnt", i), 32'(bus.draw_gnt), 32'd0);
      chk($sformatf("starve%0d_scan_gnt", i), 32'(bus.scan_gnt), 32'd1);
      next_cycle();
    end
`endif
    drive(L, 15'h0, L, L, 15'h0, 8'h00);
    repeat (3) next_cycle();

    // Streaming scan reads 0..639, expecting gap-free in-order data.
    for (int c = 0; c < 643; c++) begin
      drive(c < 640, 15'(c), L, L, 15'h0, 8'h00);
      @(negedge clk);
      if (c < 640) chk($sformatf("stream%0d_scan_gnt", c), 32'(bus.scan_gnt), 32'd1);
      if (c >= 2 && c < 642) begin
        chk($sformatf("stream%0d_rvalid", c - 2), 32'(bus.scan_rvalid), 32'd1);
        chk($sformatf("stream%0d_rdata", c - 2),  32'(bus.scan_rdata),  32'(ram_init(c - 2)));
      end else begin
        chk($sformatf("stream_edge%0d_rvalid", c), 32'(bus.scan_rvalid), 32'd0);
      end
      chk($sformatf("stream%0d_draw_rvalid", c), 32'(bus.draw_rvalid), 32'd0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
